state_sequencer: RTL and testbench
==================================

STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The block SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 state_machine_reset_n  in  1  asynchronous, active-low reset.
REQ-003 instr_in  in  16  instruction word from program memory; [15:12] opcode, [11:0] operand.
REQ-004 instr_valid  in  1  instr_in is valid this cycle.
REQ-005 stall  in  1  freezes the sequencer in EXECUTE, MEMORY or WRITEBACK.
REQ-006 resume  in  1  leaves HALT and returns to FETCH.
REQ-007 fetch_req  out  1  request to program memory for the next instruction.
REQ-008 state  out  3  current stage code, consumed by the control matrix.
REQ-009 opcode  out  4  latched opcode.
REQ-010 operand  out  12  latched operand.
REQ-011 halted  out  1  high while in HALT.
REQ-012 instr_count  out  8  count of retired instructions.
REQ-013 fetch_fault  out  1  sticky fetch-timeout flag; exists only with the timeout feature.

Function
REQ-014 State codes SHALL be: FETCH=0, WAIT_MEM=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=7; code 6 is unused.
REQ-015 Code 6 SHALL transition to HALT on the next edge.
REQ-016 FETCH SHALL assert fetch_req for exactly one cycle, then go to WAIT_MEM unconditionally.
REQ-017 WAIT_MEM SHALL hold until instr_valid=1, then latch instr_in[15:12] into opcode and instr_in[11:0] into operand on that edge, and go to DECODE.
REQ-018 Outside the WAIT_MEM accept edge, opcode and operand SHALL hold their values.
REQ-019 DECODE SHALL last one cycle: opcode 4'b1111 goes to HALT; any other opcode goes to EXECUTE.
REQ-020 EXECUTE SHALL go to MEMORY for opcodes 4'b0100 (load) and 4'b0101 (store), and to WRITEBACK otherwise.
REQ-021 MEMORY SHALL go to WRITEBACK.
REQ-022 WRITEBACK SHALL increment instr_count by 1 and go to FETCH.
REQ-023 instr_count SHALL be 8-bit modulo and wrap 255->0.
REQ-024 stall=1 in EXECUTE, MEMORY or WRITEBACK SHALL hold state, hold instr_count, and block the WRITEBACK increment.
REQ-025 stall SHALL be ignored in FETCH, WAIT_MEM, DECODE and HALT.
REQ-026 HALT SHALL hold until resume=1, then go to FETCH; halted SHALL equal (state==HALT).
REQ-027 The halt instruction SHALL NOT increment instr_count.
REQ-028 instr_valid outside WAIT_MEM SHALL be ignored.
REQ-029 Minimum latency SHALL be 5 cycles per ALU instruction and 6 cycles per load/store, from FETCH to the next FETCH, with instr_valid on the first WAIT_MEM cycle.

Reset
REQ-030 Asserting state_machine_reset_n low SHALL immediately force: state=FETCH, opcode=0, operand=0, instr_count=0, fetch_req=0, halted=0, fetch_fault=0.
REQ-031 Reset SHALL take effect at any point, including mid-instruction or in HALT; the partially executed instruction is discarded and not counted.
REQ-032 After reset deassertion, the first rising edge in FETCH SHALL assert fetch_req.
REQ-033 fetch_req SHALL be registered, so it is high during the cycle following FETCH entry.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL clear on WAIT_MEM entry and increment each WAIT_MEM cycle without instr_valid.
REQ-035 With FETCH_TIMEOUT_EN, reaching 15 SHALL set fetch_fault (sticky until reset) and go to HALT.
REQ-036 With FETCH_TIMEOUT_EN, resume SHALL NOT clear fetch_fault.
REQ-037 Macro FETCH_TIMEOUT_EN undefined: the counter and fetch_fault port SHALL be absent, and WAIT_MEM SHALL wait indefinitely.

Verification
REQ-038 Release reset, instr_in=16'h1ABC valid on the first WAIT_MEM cycle -> state sequence 0,1,2,3,5,0; opcode=1, operand=12'hABC; instr_count=1.
REQ-039 instr_in=16'h5123 -> state sequence 0,1,2,3,4,5,0; instr_count increments once.
REQ-040 instr_in=16'hF000 -> HALT after DECODE, halted=1, instr_count unchanged; resume pulse -> FETCH next edge.
REQ-041 stall=1 for 3 cycles while in EXECUTE -> state stays 3 for 3 extra cycles; instr_count unaffected until WRITEBACK.
REQ-042 Preload instr_count=255 via 255 instructions, then retire one more -> instr_count=0.
REQ-043 Reset asserted mid-MEMORY -> state=0 and outputs zero without a clock edge; with FETCH_TIMEOUT_EN, 15 cycles with no instr_valid -> fetch_fault=1, state=7.

Source files
------------

// File: rtl/state_sequencer.sv
//============================================================================
// Module   : state_sequencer
// Purpose  : Instruction stage sequencer. Walks each instruction through
//            FETCH -> WAIT_MEM -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK,
//            latches the fetched opcode/operand, counts retired instructions
//            and parks in HALT on the halt opcode (4'hF) until resumed.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clock                 in   1  sole clock, rising edge
//   state_machine_reset_n in   1  asynchronous active-low reset
//   instr_in              in  16  instruction word, [15:12] opcode, [11:0] operand
//   instr_valid           in   1  instr_in valid (only sampled in WAIT_MEM)
//   stall                 in   1  freezes EXECUTE / MEMORY / WRITEBACK
//   resume                in   1  leaves HALT towards FETCH
//   fetch_req             out  1  one-cycle program memory request
//   state                 out  3  stage code (FETCH=0 .. WRITEBACK=5, HALT=7)
//   opcode                out  4  latched opcode
//   operand               out 12  latched operand
//   halted                out  1  high while in HALT
//   instr_count           out  8  retired instruction count, modulo 256
//   fetch_fault           out  1  sticky fetch timeout (FETCH_TIMEOUT_EN only)
//----------------------------------------------------------------------------
// Build option
//   FETCH_TIMEOUT_EN : when defined, WAIT_MEM gives up after 15 cycles without
//                      instr_valid, sets fetch_fault and enters HALT. When
//                      undefined, WAIT_MEM waits indefinitely and the
//                      fetch_fault port does not exist.
//============================================================================
`default_nettype none

module state_sequencer (
   input  logic        clock,
   input  logic        state_machine_reset_n,
   input  logic [15:0] instr_in,
   input  logic        instr_valid,
   input  logic        stall,
   input  logic        resume,
   output logic        fetch_req,
   output logic [2:0]  state,
   output logic [3:0]  opcode,
   output logic [11:0] operand,
   output logic        halted,
   output logic [7:0]  instr_count
`ifdef FETCH_TIMEOUT_EN
   ,
   output logic        fetch_fault
`endif
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_WAIT_MEM  = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALT      = 3'd7
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b0100;
   localparam logic [3:0] OP_STORE = 4'b0101;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   state_t      state_q, state_d;
   logic        fetch_req_q;
   logic        halted_q;
   logic [3:0]  opcode_q;
   logic [11:0] operand_q;
   logic [7:0]  count_q;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [3:0] TMO_LAST = 4'd14;   // 15th idle WAIT_MEM cycle
   logic [3:0]  tmo_q;
   logic        fault_q;
   logic        tmo_hit;

   assign tmo_hit = (state_q == ST_WAIT_MEM) && !instr_valid && (tmo_q == TMO_LAST);
`endif

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:     state_d = ST_WAIT_MEM;
         ST_WAIT_MEM: begin
            if (instr_valid)
               state_d = ST_DECODE;
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_hit)
               state_d = ST_HALT;
`endif
         end
         ST_DECODE:    state_d = (opcode_q == OP_HALT) ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE: begin
            if (!stall)
               state_d = ((opcode_q == OP_LOAD) || (opcode_q == OP_STORE))
                         ? ST_MEMORY : ST_WRITEBACK;
         end
         ST_MEMORY:    if (!stall) state_d = ST_WRITEBACK;
         ST_WRITEBACK: if (!stall) state_d = ST_FETCH;
         ST_HALT:      if (resume) state_d = ST_FETCH;
         default:      state_d = ST_HALT;   // unused code 6 recovers via HALT
      endcase
   end

   always_ff @(posedge clock or negedge state_machine_reset_n) begin
      if (!state_machine_reset_n) begin
         state_q     <= ST_FETCH;
         fetch_req_q <= 1'b0;
         halted_q    <= 1'b0;
         opcode_q    <= 4'd0;
         operand_q   <= 12'd0;
         count_q     <= 8'd0;
`ifdef FETCH_TIMEOUT_EN
         tmo_q       <= 4'd0;
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         // Request goes out on the edge that leaves FETCH, so it is high
         // for exactly the first WAIT_MEM cycle.
         fetch_req_q <= (state_q == ST_FETCH);
         halted_q    <= (state_d == ST_HALT);

         if ((state_q == ST_WAIT_MEM) && instr_valid) begin
            opcode_q  <= instr_in[15:12];
            operand_q <= instr_in[11:0];
         end

         // Retire only when WRITEBACK actually completes (not stalled).
         if ((state_q == ST_WRITEBACK) && !stall)
            count_q <= count_q + 8'd1;

`ifdef FETCH_TIMEOUT_EN
         // Held at zero outside WAIT_MEM, which clears it on entry.
         if (state_q != ST_WAIT_MEM)
            tmo_q <= 4'd0;
         else if (!instr_valid)
            tmo_q <= tmo_q + 4'd1;

         if (tmo_hit)
            fault_q <= 1'b1;
`endif
      end
   end

   assign fetch_req   = fetch_req_q;
   assign state       = state_q;
   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign halted      = halted_q;
   assign instr_count = count_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_fault = fault_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_state_sequencer.sv
//============================================================================
// Module   : tb_state_sequencer
// Purpose  : Directed self-checking bench for state_sequencer. Expected
//            stage codes and counts come from a small bench-side model of
//            the instruction flow.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_state_sequencer;

   logic        clock;
   logic        state_machine_reset_n;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic        stall;
   logic        resume;
   logic        fetch_req;
   logic [2:0]  state;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic        halted;
   logic [7:0]  instr_count;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_fault;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_cnt;

   state_sequencer dut (
      .clock                 (clock),
      .state_machine_reset_n (state_machine_reset_n),
      .instr_in              (instr_in),
      .instr_valid           (instr_valid),
      .stall                 (stall),
      .resume                (resume),
      .fetch_req             (fetch_req),
      .state                 (state),
      .opcode                (opcode),
      .operand               (operand),
      .halted                (halted),
      .instr_count           (instr_count)
`ifdef FETCH_TIMEOUT_EN
      ,
      .fetch_fault           (fetch_fault)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at negedge.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Run one instruction from FETCH with valid on the first WAIT_MEM cycle.
   task automatic run_instr(input logic [15:0] ins);
      logic [3:0] op;
      op = ins[15:12];
      check_val("st_fetch", {29'd0, state}, 32'd0);
      step();
      check_val("st_wait", {29'd0, state}, 32'd1);
      check_val("fetch_req_hi", {31'd0, fetch_req}, 32'd1);
      instr_in    = ins;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      instr_in    = ~ins;            // must not disturb the latched fields
      check_val("st_decode", {29'd0, state}, 32'd2);
      check_val("fetch_req_lo", {31'd0, fetch_req}, 32'd0);
      check_val("opcode", {28'd0, opcode}, {28'd0, op});
      check_val("operand", {20'd0, operand}, {20'd0, ins[11:0]});
      step();
      if (op == 4'hF) begin
         check_val("st_halt", {29'd0, state}, 32'd7);
         check_val("halted", {31'd0, halted}, 32'd1);
         check_val("cnt_halt", {24'd0, instr_count}, {24'd0, exp_cnt});
         return;
      end
      check_val("st_exec", {29'd0, state}, 32'd3);
      if (op == 4'h4 || op == 4'h5) begin
         step();
         check_val("st_mem", {29'd0, state}, 32'd4);
      end
      step();
      check_val("st_wb", {29'd0, state}, 32'd5);
      check_val("cnt_wb", {24'd0, instr_count}, {24'd0, exp_cnt});
      step();
      exp_cnt = exp_cnt + 8'd1;
      check_val("st_refetch", {29'd0, state}, 32'd0);
      check_val("cnt_retire", {24'd0, instr_count}, {24'd0, exp_cnt});
      check_val("opcode_hold", {28'd0, opcode}, {28'd0, op});
   endtask

   initial begin
      state_machine_reset_n = 1'b0;
      instr_in    = 16'h0000;
      instr_valid = 1'b0;
      stall       = 1'b0;
      resume      = 1'b0;
      exp_cnt     = 8'd0;

      // Reset state
      repeat (2) @(negedge clock);
      check_val("rst_state", {29'd0, state}, 32'd0);
      check_val("rst_freq", {31'd0, fetch_req}, 32'd0);
      check_val("rst_opcode", {28'd0, opcode}, 32'd0);
      check_val("rst_operand", {20'd0, operand}, 32'd0);
      check_val("rst_count", {24'd0, instr_count}, 32'd0);
      check_val("rst_halted", {31'd0, halted}, 32'd0);
      state_machine_reset_n = 1'b1;

      // ALU, load, store, ALU
      run_instr(16'h1ABC);
      run_instr(16'h5123);
      run_instr(16'h4FED);
      run_instr(16'h0000);

      // Halt: stall/valid ignored while halted, resume returns to FETCH
      run_instr(16'hF000);
      stall       = 1'b1;
      instr_valid = 1'b1;
      step();
      check_val("halt_hold", {29'd0, state}, 32'd7);
      step();
      check_val("halt_hold2", {29'd0, state}, 32'd7);
      check_val("halt_cnt", {24'd0, instr_count}, {24'd0, exp_cnt});
      stall       = 1'b0;
      instr_valid = 1'b0;
      resume      = 1'b1;
      step();
      resume      = 1'b0;
      check_val("resume_fetch", {29'd0, state}, 32'd0);
      check_val("resume_halted", {31'd0, halted}, 32'd0);
      check_val("resume_opcode", {28'd0, opcode}, 32'd15);

      // WAIT_MEM holds without instr_valid (default build waits forever)
`ifndef FETCH_TIMEOUT_EN
      step();
      repeat (20) step();
      check_val("wait_forever", {29'd0, state}, 32'd1);
      instr_in    = 16'h3777;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      check_val("late_decode", {29'd0, state}, 32'd2);
      check_val("late_operand", {20'd0, operand}, 32'h777);
      repeat (3) step();
      exp_cnt = exp_cnt + 8'd1;
      check_val("late_retire", {29'd0, state}, 32'd0);
      check_val("late_cnt", {24'd0, instr_count}, {24'd0, exp_cnt});
`endif

      // Stall: ignored in WAIT_MEM/DECODE, holds EXECUTE and WRITEBACK
      step();
      instr_in    = 16'h2345;
      instr_valid = 1'b1;
      stall       = 1'b1;
      step();
      instr_valid = 1'b0;
      check_val("stall_decode", {29'd0, state}, 32'd2);
      step();
      check_val("stall_exec_in", {29'd0, state}, 32'd3);
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("stall_exec_hold", {29'd0, state}, 32'd3);
      end
      stall = 1'b0;
      step();
      check_val("stall_wb", {29'd0, state}, 32'd5);
      stall = 1'b1;
      step();
      check_val("stall_wb_hold", {29'd0, state}, 32'd5);
      check_val("stall_wb_cnt", {24'd0, instr_count}, {24'd0, exp_cnt});
      stall = 1'b0;
      step();
      exp_cnt = exp_cnt + 8'd1;
      check_val("stall_retire", {29'd0, state}, 32'd0);
      check_val("stall_cnt", {24'd0, instr_count}, {24'd0, exp_cnt});

      // Asynchronous reset in the middle of MEMORY
      step();
      instr_in    = 16'h5123;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      step();
      check_val("pre_rst_mem", {29'd0, state}, 32'd4);
      #2 state_machine_reset_n = 1'b0;
      #1;
      check_val("arst_state", {29'd0, state}, 32'd0);
      check_val("arst_opcode", {28'd0, opcode}, 32'd0);
      check_val("arst_operand", {20'd0, operand}, 32'd0);
      check_val("arst_count", {24'd0, instr_count}, 32'd0);
      check_val("arst_freq", {31'd0, fetch_req}, 32'd0);
      check_val("arst_halted", {31'd0, halted}, 32'd0);
      @(negedge clock);
      state_machine_reset_n = 1'b1;
      exp_cnt = 8'd0;

`ifdef FETCH_TIMEOUT_EN
      // Timeout: 15 idle WAIT_MEM cycles -> fault and HALT
      check_val("tmo_fault0", {31'd0, fetch_fault}, 32'd0);
      step();
      for (int i = 0; i < 14; i++) step();
      check_val("tmo_pre", {29'd0, state}, 32'd1);
      check_val("tmo_pre_fault", {31'd0, fetch_fault}, 32'd0);
      step();
      check_val("tmo_halt", {29'd0, state}, 32'd7);
      check_val("tmo_fault", {31'd0, fetch_fault}, 32'd1);
      resume = 1'b1;
      step();
      resume = 1'b0;
      check_val("tmo_resume", {29'd0, state}, 32'd0);
      check_val("tmo_sticky", {31'd0, fetch_fault}, 32'd1);
      run_instr(16'h1111);
      @(negedge clock);
      state_machine_reset_n = 1'b0;
      @(negedge clock);
      check_val("tmo_rst_clear", {31'd0, fetch_fault}, 32'd0);
      state_machine_reset_n = 1'b1;
      exp_cnt = 8'd0;
`endif

      // Counter wrap: 255 retirements, then one more wraps to 0
      for (int i = 0; i < 255; i++)
         run_instr({4'h6, 4'h0, i[7:0]});
      check_val("cnt_255", {24'd0, instr_count}, 32'd255);
      run_instr(16'h7001);
      check_val("cnt_wrap", {24'd0, instr_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
